memwb: RTL and testbench

- Memory/writeback pipeline stage that sits directly downstream of the execute stage.
- Accepts the execute stage's submit bundle (data, addr, reg_ie, mem_access, mem_we) under a ready/submit handshake.
- Performs load/store transactions on the data-memory bus with a req/ack handshake.
- Drives register-file write-enables and write data back into execute, one instruction at a time.

---
 rtl/memwb_pkg.sv | 10 +
 rtl/memwb.sv | 170 +++++++++++++++++
 tb/tb_memwb.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/memwb_pkg.sv
// Shared definitions for the memory/writeback stage: FSM state encoding.
package memwb_pkg;

  // Two-state control: IDLE accepts work, BUSY owns the data-memory bus.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } memwb_state_e;

endpackage

// File: rtl/memwb.sv
// Memory/writeback stage: accepts execute's submit bundle, runs load/store
// transactions on the data bus and returns one register writeback pulse per
// instruction. ALU results pass through in one cycle; memory ops hold o_ready
// low from acceptance until the cycle their writeback (or fault) is issued.
module memwb
  import memwb_pkg::*;
#(
  parameter int RW      = 16,
  parameter int REGNO   = 8,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_submit,
  output logic             o_ready,
  input  logic [RW-1:0]    i_data,
  input  logic [RW-1:0]    i_addr,
  input  logic [REGNO-1:0] i_reg_ie,
  input  logic             i_mem_access,
  input  logic             i_mem_we,
  output logic             o_mem_req,
  output logic [RW-1:0]    o_mem_addr,
  output logic [RW-1:0]    o_mem_data,
  output logic             o_mem_we,
  input  logic             i_mem_ack,
  input  logic [RW-1:0]    i_mem_data,
  output logic [REGNO-1:0] o_reg_ie,
  output logic [RW-1:0]    o_reg_data,
  output logic             o_mem_fault
);

  // A zero TIMEOUT means wait for the ack forever.
  localparam bit            TO_EN  = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

  memwb_state_e     state_q,    state_d;
  logic             ready_q,    ready_d;
  logic             mem_req_q,  mem_req_d;
  logic [RW-1:0]    mem_addr_q, mem_addr_d;
  logic [RW-1:0]    mem_data_q, mem_data_d;
  logic             mem_we_q,   mem_we_d;
  logic [REGNO-1:0] reg_ie_q,   reg_ie_d;
  logic [RW-1:0]    reg_data_q, reg_data_d;
  logic             fault_q,    fault_d;
  logic [REGNO-1:0] pend_ie_q,  pend_ie_d;
  logic [TO_W-1:0]  cnt_q,      cnt_d;

  logic accept_s;
  logic expired_s;

  assign accept_s  = i_submit & ready_q;
  assign expired_s = TO_EN && (cnt_q == TO_MAX);

  // Next-state logic for the IDLE/BUSY controller, its counter and outputs.
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = mem_we_q;
    reg_ie_d   = '0;            // writeback enable is only ever a pulse
    reg_data_d = reg_data_q;
    fault_d    = 1'b0;          // fault is only ever a pulse
    pend_ie_d  = pend_ie_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (i_mem_access) begin
            // Launch the bus request; hold off execute until it resolves.
            state_d    = ST_BUSY;
            ready_d    = 1'b0;
            mem_req_d  = 1'b1;
            mem_addr_d = i_addr;
            mem_data_d = i_data;
            mem_we_d   = i_mem_we;
            pend_ie_d  = i_reg_ie;
            cnt_d      = '0;
          end else begin
            // ALU result: write back next cycle, stay ready.
            reg_ie_d   = i_reg_ie;
            reg_data_d = i_data;
          end
        end else begin
          // Nothing offered; stray acks are ignored here.
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        if (i_mem_ack) begin
          // Ack wins over a same-cycle timeout expiry.
          state_d   = ST_IDLE;
          ready_d   = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            reg_ie_d   = pend_ie_q;
            reg_data_d = i_mem_data;
          end else begin
            // Stores produce no writeback and leave reg_data untouched.
            reg_ie_d = '0;
          end
        end else if (expired_s) begin
          // Bus never answered: abandon the access without a writeback.
          state_d   = ST_IDLE;
          ready_d   = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          fault_d   = 1'b1;
        end else if (cnt_q != TO_MAX) begin
          cnt_d = cnt_q + TO_ONE;
        end else begin
          // Counter saturates at TIMEOUT (only reachable with TIMEOUT=0).
          cnt_d = cnt_q;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        ready_d   = 1'b1;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset to the idle, ready state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      reg_ie_q   <= '0;
      reg_data_q <= '0;
      fault_q    <= 1'b0;
      pend_ie_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      reg_ie_q   <= reg_ie_d;
      reg_data_q <= reg_data_d;
      fault_q    <= fault_d;
      pend_ie_q  <= pend_ie_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_data  = mem_data_q;
  assign o_mem_we    = mem_we_q;
  assign o_reg_ie    = reg_ie_q;
  assign o_reg_data  = reg_data_q;
  assign o_mem_fault = fault_q;

endmodule

// File: tb/tb_memwb.sv
// Self-checking bench for memwb: ALU vector table, directed multi-cycle
// sequences, then random transactions against a transaction-level model.
module tb_memwb;

  localparam int RW    = 16;
  localparam int REGNO = 8;
  localparam int TMO   = 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_submit;
  logic             o_ready;
  logic [RW-1:0]    i_data;
  logic [RW-1:0]    i_addr;
  logic [REGNO-1:0] i_reg_ie;
  logic             i_mem_access;
  logic             i_mem_we;
  logic             o_mem_req;
  logic [RW-1:0]    o_mem_addr;
  logic [RW-1:0]    o_mem_data;
  logic             o_mem_we;
  logic             i_mem_ack;
  logic [RW-1:0]    i_mem_data;
  logic [REGNO-1:0] o_reg_ie;
  logic [RW-1:0]    o_reg_data;
  logic             o_mem_fault;

  int n_chk = 0;
  int n_err = 0;
  logic [RW-1:0] model_rd;   // expected o_reg_data (persistent)

  memwb #(.RW(RW), .REGNO(REGNO), .TIMEOUT(TMO), .TO_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_submit(i_submit), .o_ready(o_ready),
    .i_data(i_data), .i_addr(i_addr), .i_reg_ie(i_reg_ie),
    .i_mem_access(i_mem_access), .i_mem_we(i_mem_we),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_we(o_mem_we), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .o_reg_ie(o_reg_ie), .o_reg_data(o_reg_data), .o_mem_fault(o_mem_fault)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic             submit;
    logic [RW-1:0]    data;
    logic [REGNO-1:0] ie;
    logic [REGNO-1:0] exp_ie;
    logic [RW-1:0]    exp_data;
  } alu_vec_t;

  alu_vec_t vecs[6];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_submit = 1'b0; i_data = '0; i_addr = '0; i_reg_ie = '0;
    i_mem_access = 1'b0; i_mem_we = 1'b0; i_mem_ack = 1'b0; i_mem_data = '0;
  endtask

  task automatic submit_mem(input logic [RW-1:0] addr, input logic [RW-1:0] data,
                            input logic [REGNO-1:0] ie, input logic we);
    i_submit = 1'b1; i_addr = addr; i_data = data; i_reg_ie = ie;
    i_mem_access = 1'b1; i_mem_we = we;
    tick();
    i_submit = 1'b0; i_mem_access = 1'b0;
  endtask

  // One memory transaction with the ack delayed 'd' request cycles (d > TMO: none).
  task automatic run_mem(input logic [RW-1:0] addr, input logic [RW-1:0] data,
                         input logic [REGNO-1:0] ie, input logic we, input int d,
                         input logic [RW-1:0] rdata, input string tag);
    bit ok_hold;
    bit done;
    int nreq;
    done = (d <= TMO);
    nreq = done ? d + 1 : TMO + 1;
    submit_mem(addr, data, ie, we);
    ok_hold = 1'b1;
    for (int k = 0; k < nreq; k++) begin
      if (o_mem_req !== 1'b1 || o_mem_addr !== addr || o_mem_data !== data ||
          o_mem_we !== we || o_ready !== 1'b0 || o_reg_ie !== '0 || o_mem_fault !== 1'b0)
        ok_hold = 1'b0;
      if (k == d) begin i_mem_ack = 1'b1; i_mem_data = rdata; end
      tick();
      i_mem_ack = 1'b0;
    end
    chk({tag, "_hold"}, {31'd0, ok_hold}, 32'd1);
    if (done && !we) model_rd = rdata;
    chk({tag, "_req"},   {31'd0, o_mem_req}, 32'd0);
    chk({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    chk({tag, "_fault"}, {31'd0, o_mem_fault}, {31'd0, !done});
    chk({tag, "_ie"},    {24'd0, o_reg_ie}, (done && !we) ? {24'd0, ie} : 32'd0);
    chk({tag, "_rdata"}, {16'd0, o_reg_data}, {16'd0, model_rd});
  endtask

  initial begin
    idle_inputs();
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    // Reset state
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_outs", {o_mem_req, o_mem_we, o_mem_fault, o_reg_ie, 21'd0},
        32'd0);
    chk("rst_busdata", {o_mem_addr, o_mem_data}, 32'd0);
    chk("rst_rdata", {16'd0, o_reg_data}, 32'd0);
    model_rd = '0;

    // Stray ack in IDLE
    i_mem_ack = 1'b1; i_mem_data = 16'hFFFF;
    tick();
    i_mem_ack = 1'b0;
    chk("stray_ie", {24'd0, o_reg_ie}, 32'd0);
    chk("stray_state", {29'd0, o_ready, o_mem_req, o_mem_fault}, 32'd4);
    chk("stray_rdata", {16'd0, o_reg_data}, 32'd0);

    // ALU table, applied back-to-back
    vecs[0] = '{1'b1, 16'h1234, 8'h04, 8'h04, 16'h1234};
    vecs[1] = '{1'b1, 16'hABCD, 8'h80, 8'h80, 16'hABCD};
    vecs[2] = '{1'b1, 16'h0001, 8'h01, 8'h01, 16'h0001};
    vecs[3] = '{1'b0, 16'hFFFF, 8'hFF, 8'h00, 16'h0001};
    vecs[4] = '{1'b1, 16'h5555, 8'h00, 8'h00, 16'h5555};
    vecs[5] = '{1'b1, 16'h8000, 8'h40, 8'h40, 16'h8000};
    for (int v = 0; v < 6; v++) begin
      i_submit = vecs[v].submit; i_data = vecs[v].data; i_reg_ie = vecs[v].ie;
      i_mem_access = 1'b0;
      tick();
      chk($sformatf("alu%0d_ie", v), {24'd0, o_reg_ie}, {24'd0, vecs[v].exp_ie});
      chk($sformatf("alu%0d_data", v), {16'd0, o_reg_data}, {16'd0, vecs[v].exp_data});
      chk($sformatf("alu%0d_ready", v), {31'd0, o_ready}, 32'd1);
    end
    idle_inputs();
    tick();
    chk("alu_pulse_end", {24'd0, o_reg_ie}, 32'd0);
    model_rd = 16'h8000;

    // Load with slow bus: ack on the 4th request cycle
    run_mem(16'h0100, 16'h0000, 8'h02, 1'b0, 3, 16'hBEEF, "load_slow");
    tick();
    chk("load_pulse_end", {24'd0, o_reg_ie}, 32'd0);

    // Store with same-cycle ack
    run_mem(16'h0200, 16'h00AA, 8'h08, 1'b1, 0, 16'h1111, "store");

    // Timeout with no ack, then ack exactly at expiry
    run_mem(16'h0300, 16'h0000, 8'h10, 1'b0, TMO + 1, 16'h0000, "tmo");
    tick();
    chk("tmo_fault_end", {31'd0, o_mem_fault}, 32'd0);
    run_mem(16'h0300, 16'h0000, 8'h10, 1'b0, TMO, 16'h1357, "tmo_ack");

    // Reset mid-load, then a late ack
    submit_mem(16'h0400, 16'h0000, 8'h20, 1'b0);
    tick();
    chk("rstmid_busy", {30'd0, o_mem_req, o_ready}, 32'd2);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    model_rd = '0;
    chk("rstmid_outs", {29'd0, o_mem_req, o_ready, o_mem_fault}, 32'd2);
    chk("rstmid_ie", {24'd0, o_reg_ie}, 32'd0);
    i_mem_ack = 1'b1; i_mem_data = 16'h7777;
    tick();
    i_mem_ack = 1'b0;
    chk("rstmid_lateack_ie", {24'd0, o_reg_ie}, 32'd0);
    chk("rstmid_lateack_rd", {16'd0, o_reg_data}, 32'd0);
    chk("rstmid_lateack_st", {30'd0, o_mem_req, o_ready}, 32'd1);

    // Random transactions against the transaction-level model
    for (int t = 0; t < 300; t++) begin
      int kind;
      logic [RW-1:0] a, dd, rd;
      logic [REGNO-1:0] ie;
      int sel;
      kind = $urandom_range(0, 2);
      a  = RW'($urandom);
      dd = RW'($urandom);
      rd = RW'($urandom);
      sel = $urandom_range(0, 8);
      ie = (sel == 8) ? '0 : REGNO'(1 << sel);
      if (kind == 0) begin
        i_submit = 1'b1; i_data = dd; i_reg_ie = ie; i_mem_access = 1'b0;
        tick();
        idle_inputs();
        model_rd = dd;
        chk("rnd_alu_ie", {24'd0, o_reg_ie}, {24'd0, ie});
        chk("rnd_alu_data", {16'd0, o_reg_data}, {16'd0, model_rd});
        chk("rnd_alu_ready", {31'd0, o_ready}, 32'd1);
      end else begin
        run_mem(a, dd, ie, (kind == 2), $urandom_range(0, TMO + 2), rd, "rnd_mem");
      end
      if ($urandom_range(0, 3) == 0) begin
        i_mem_ack = 1'b1; i_mem_data = RW'($urandom);
        tick();
        i_mem_ack = 1'b0;
        chk("rnd_idle_ie", {24'd0, o_reg_ie}, 32'd0);
        chk("rnd_idle_rd", {16'd0, o_reg_data}, {16'd0, model_rd});
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
